// File: rtl/speculoos_pkg.sv
// Shared encodings for the Speculoos shadow-stack path: OR1K opcodes of interest
// and the event type tags exchanged between observer and monitor.
package speculoos_pkg;

  localparam logic [5:0] OP_JAL  = 6'h01;
  localparam logic [5:0] OP_JR   = 6'h11;
  localparam logic [5:0] OP_JALR = 6'h12;

  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_CALL = 2'b01,
    EV_RET  = 2'b10
  } ev_type_e;

endpackage

// File: rtl/observer_fifo.sv
// Synchronous FIFO with clear; occupancy counter disambiguates full from empty
// because the pointers wrap at DEPTH and carry no extra lap bit.
module observer_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     clr_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             doPush, doPop;

  assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rdPtr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (clr_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   level_d = level_q + (PTR_W+1)'(1);
        2'b01:   level_d = level_q - (PTR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clr_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/callret_observer.sv
// Call/return observer: decodes retiring l.jal/l.jalr/l.jr, registers one event
// per strobe and queues it for the monitor behind a first-word-fall-through FIFO.
module callret_observer #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 8,
  parameter int LINK_REG   = 9,
  parameter int RET_OFFSET = 8,
  parameter bit EN_JALR    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     obs_en_i,
  input  logic                     obs_insn_valid_i,
  input  logic [31:0]              obs_insn_i,
  input  logic [ADDR_W-1:0]        obs_pc_i,
  input  logic [ADDR_W-1:0]        obs_target_i,
  output logic                     obs_valid_o,
  input  logic                     obs_ready_i,
  output logic [1:0]               obs_type_o,
  output logic [ADDR_W-1:0]        obs_address_o,
  output logic [$clog2(DEPTH):0]   obs_level_o,
  output logic                     obs_overflow_o,
  input  logic                     obs_clr_i
);

  import speculoos_pkg::*;

  localparam int ENTRY_W = 2 + ADDR_W;

  logic [5:0]        opcode;
  logic [4:0]        rb;
  logic              decodeEn, isCall, isRet;
  logic              unusedInsnBits;

  logic              capValid_q, capValid_d;
  ev_type_e          capType_q, capType_d;
  logic [ADDR_W-1:0] capAddr_q, capAddr_d;
  logic              overflow_q, overflow_d;

  logic [ENTRY_W-1:0] headData;
  logic               fifoFull, fifoEmpty, popEn;

  assign opcode         = obs_insn_i[31:26];
  assign rb             = obs_insn_i[15:11];
  assign unusedInsnBits = ^{obs_insn_i[25:16], obs_insn_i[10:0]};
  assign decodeEn       = obs_insn_valid_i & obs_en_i;
  assign isCall         = (opcode == OP_JAL) || (EN_JALR && (opcode == OP_JALR));
  assign isRet          = (opcode == OP_JR) && (rb == 5'(LINK_REG));

  // Capture stage holds at most one event; its valid bit lives for a single cycle.
  always_comb begin
    capValid_d = 1'b0;
    capType_d  = capType_q;
    capAddr_d  = capAddr_q;
    if (!obs_clr_i && decodeEn) begin
      if (isCall) begin
        capValid_d = 1'b1;
        capType_d  = EV_CALL;
        capAddr_d  = obs_pc_i + ADDR_W'(RET_OFFSET);
      end else if (isRet) begin
        capValid_d = 1'b1;
        capType_d  = EV_RET;
        capAddr_d  = obs_target_i;
      end
    end
  end

  assign popEn = obs_ready_i & ~fifoEmpty;

  always_comb begin
    overflow_d = overflow_q;
    if (obs_clr_i)                                overflow_d = 1'b0;
    else if (capValid_q && fifoFull && !popEn)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capValid_q <= 1'b0;
      capType_q  <= EV_NONE;
      capAddr_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      capValid_q <= capValid_d;
      capType_q  <= capType_d;
      capAddr_q  <= capAddr_d;
      overflow_q <= overflow_d;
    end
  end

  observer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (capValid_q),
    .data_i  ({capType_q, capAddr_q}),
    .pop_i   (obs_ready_i),
    .clr_i   (obs_clr_i),
    .data_o  (headData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (obs_level_o)
  );

  assign obs_valid_o    = ~fifoEmpty;
  assign obs_type_o     = fifoEmpty ? EV_NONE : headData[ENTRY_W-1 -: 2];
  assign obs_address_o  = fifoEmpty ? '0 : headData[ADDR_W-1:0];
  assign obs_overflow_o = overflow_q;

endmodule

// File: doc/callret_observer.md
# callret_observer

Parametrised call/return observer for the Speculoos shadow-stack path on mor1kx. It decodes the retiring instruction stream and recognises calls (l.jal, optionally l.jalr) and returns (l.jr through the link register). It queues one tagged event per recognised instruction in an internal FIFO and hands events to the monitor over a valid/ready handshake. Compared with the single-pulse observer it replaces, it adds:
- an explicit instruction strobe, so stalls cannot duplicate events;
- a configurable link register and return offset;
- buffering, with overflow reporting.

## Interface
Parameters:
- ADDR_W, 32, width of PC, target and event address.
- DEPTH, 8, event FIFO entries; power of two, 2..64.
- LINK_REG, 9, GPR index whose l.jr is a return.
- RET_OFFSET, 8, added to call PC to form the pushed return address (covers the delay slot).
- EN_JALR, 1, 1 = l.jalr (opcode 0x12) also counts as a call.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- obs_en_i  in  1  observation enable; 0 = decode ignored, FIFO still drains.
- obs_insn_valid_i  in  1  one-cycle strobe, one per instruction retired.
- obs_insn_i  in  32  instruction word, qualified by strobe.
- obs_pc_i  in  ADDR_W  PC of that instruction.
- obs_target_i  in  ADDR_W  value of rB for l.jr, qualified by strobe.
- obs_valid_o  out  1  event available.
- obs_ready_i  in  1  monitor accepts the event.
- obs_type_o  out  2  01 = CALL, 10 = RET; 00 when not valid.
- obs_address_o  out  ADDR_W  return address (CALL) or jump target (RET).
- obs_level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- obs_overflow_o  out  1  sticky; at least one event was dropped.
- obs_clr_i  in  1  synchronous clear of FIFO and overflow flag.

## Operation
- Decoding is done only when obs_insn_valid_i=1 and obs_en_i=1.
- opcode = insn[31:26], rB = insn[15:11].
- CALL: opcode 0x01, or opcode 0x12 when EN_JALR=1. Address = obs_pc_i + RET_OFFSET, mod 2^ADDR_W.
- RET: opcode 0x11 and rB == LINK_REG. Address = obs_target_i.
- Anything else produces no event. l.jr through any other register is not a return.
- Capture stage: one register holding {type, address}, loaded when a decode produces an event. Its valid bit clears on any cycle with no new event.
- The capture register writes into the FIFO on the next cycle.
- FIFO full while a capture is pending:
  - If a pop happens in the same cycle, the write succeeds (simultaneous pop and push at full are allowed).
  - Otherwise the event is dropped and obs_overflow_o is set. It stays set until obs_clr_i or reset.
- Output is first-word fall-through: obs_valid_o = FIFO not empty, and the head entry drives obs_type_o and obs_address_o.
- A pop happens when obs_valid_o & obs_ready_i.
- obs_clr_i empties the FIFO, clears the capture register and clears overflow. It has priority over a same-cycle push and pop.
- obs_en_i falling while an event is in flight: events already captured are still delivered.

## Timing
- Reset values: obs_valid_o=0, obs_type_o=00, obs_address_o=0, obs_level_o=0, obs_overflow_o=0. The FIFO and capture stage are empty.
- Latency: strobe in cycle N, then the event is in the capture register in N+1 and obs_valid_o=1 in N+2 (FIFO initially empty, obs_clr_i low).
- Back-to-back strobes give one event per cycle. Sustained throughput is 1 per cycle when obs_ready_i is held high.
- obs_level_o updates on the edge after each push or pop; it is unchanged on a simultaneous push and pop.
- Head outputs are stable while obs_valid_o=1 and obs_ready_i=0.
- Asserting reset at any time clears all state immediately. Pending and captured events are lost and no overflow is flagged.
- Pointers are log2(DEPTH) bits wide and wrap to 0 after DEPTH-1. Full versus empty is distinguished by the occupancy counter.

## Structure
- Shared package speculoos_pkg holds:
  - opcode constants OP_JAL=0x01, OP_JR=0x11, OP_JALR=0x12;
  - event type encodings EV_NONE, EV_CALL, EV_RET.
- The monitor imports the same encodings.
- Sub-module observer_fifo: parametrised synchronous FIFO (width, depth) with push, pop, clear, full, empty and level. It is instantiated once, with width 2+ADDR_W.
- Decode and capture logic live in callret_observer itself.

## Test plan
- Reset, then strobe l.jal at pc 0x1000 with obs_ready_i=1. Required: in N+2, obs_valid_o=1, type 01, address 0x1008, for exactly one cycle.
- Strobe l.jr r9 with obs_target_i=0x2004, then l.jr r3. Required: exactly one RET event, address 0x2004; no event for r3.
- Strobe l.jalr with EN_JALR=0, then with EN_JALR=1. Required: no event with 0; a CALL with pc+8 with 1.
- Hold obs_ready_i=0 and issue DEPTH+1 calls. Required: obs_level_o=DEPTH, overflow=1, and the first DEPTH events drain in order.
- With the FIFO full, push and pop in the same cycle. Required: level stays DEPTH, no overflow, the new event is at the tail. Then assert obs_clr_i: level 0, overflow 0.
- Assert reset with 3 queued events. Required: obs_valid_o=0 and level 0 immediately; no events after release.
